// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

    localparam int BIN_W  = 10;
    localparam int BCD_W  = 12;
    localparam int N_ITER = 10;

    localparam logic [BIN_W-1:0] MAX_VAL    = 10'd999;
    localparam logic [3:0]       LAST_ITER  = 4'(N_ITER - 1);
    localparam logic [BCD_W-1:0] SAT_DIGITS = 12'h999;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_SHIFT = 2'b01;
    localparam state_t ST_DONE  = 2'b10;

    function automatic logic above_max(input logic [BIN_W-1:0] value);
        return (value > MAX_VAL);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] corrected
);

    // Combinational add-3 correction for one BCD digit
    always_comb begin
        corrected = digit;
        if (digit >= 4'd5) begin
            corrected = digit + 4'd3;
        end else begin
            corrected = digit;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential 10-bit binary to 3-digit BCD converter, one shift-add-3 iteration per cycle.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [BIN_W-1:0]  Bin,
    output logic [BCD_W-1:0]  Digits,
    output logic              Busy,
    output logic              Done,
    output logic              Ovf
);

    state_t             state_r;
    state_t             next_state_s;
    logic [BIN_W-1:0]   operand_r;
    logic [BCD_W-1:0]   scratch_r;
    logic [3:0]         iter_r;
    logic               ovf_pend_r;
    logic [BCD_W-1:0]   digits_r;
    logic               busy_r;
    logic               done_r;
    logic               ovf_r;
    logic [BCD_W-1:0]   corrected_s;
    logic [BCD_W-1:0]   scratch_next_s;
    logic               last_iter_s;

    for (genvar d = 0; d < 3; d++) begin : g_digit
        bcd_add3 u_add3 (
            .digit     (scratch_r[4*d +: 4]),
            .corrected (corrected_s[4*d +: 4])
        );
    end

    // The thousands bit falls off the top here, which is what gives modulo-1000 results.
    // Shift the corrected scratch left, pulling in the operand MSB
    always_comb begin
        scratch_next_s = {corrected_s[BCD_W-2:0], operand_r[BIN_W-1]};
        last_iter_s    = (iter_r == LAST_ITER);
    end

    // Next-state logic
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    next_state_s = ST_SHIFT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_iter_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand capture, iteration datapath and registered outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            operand_r  <= 10'd0;
            scratch_r  <= 12'd0;
            iter_r     <= 4'd0;
            ovf_pend_r <= 1'b0;
            digits_r   <= 12'h000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (Start) begin
                        operand_r  <= Bin;
                        scratch_r  <= 12'd0;
                        iter_r     <= 4'd0;
                        ovf_pend_r <= above_max(Bin);
                        busy_r     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    scratch_r <= scratch_next_s;
                    operand_r <= {operand_r[BIN_W-2:0], 1'b0};
                    iter_r    <= iter_r + 4'd1;
                    if (last_iter_s) begin
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        ovf_r    <= ovf_pend_r;
                        digits_r <= (SATURATE && ovf_pend_r) ? SAT_DIGITS : scratch_next_s;
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign Digits = digits_r;
    assign Busy   = busy_r;
    assign Done   = done_r;
    assign Ovf    = ovf_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq, saturating and wrapping builds side by side.
module tb_bin2bcd_seq;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [9:0]  Bin;
    logic [11:0] digits1, digits0;
    logic        busy1, busy0, done1, done0, ovf1, ovf0;

    int tests = 0;
    int fails = 0;

    bin2bcd_seq #(.SATURATE(1'b1)) u_sat (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Bin(Bin),
        .Digits(digits1), .Busy(busy1), .Done(done1), .Ovf(ovf1)
    );

    bin2bcd_seq #(.SATURATE(1'b0)) u_wrap (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Bin(Bin),
        .Digits(digits0), .Busy(busy0), .Done(done0), .Ovf(ovf0)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: decimal value by plain arithmetic, then split into digits
    function automatic logic [11:0] model(input int b, input bit sat);
        int v;
        v = (sat && b > 999) ? 999 : (b % 1000);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic bit nibs_ok(input logic [11:0] d);
        return (d[11:8] <= 4'd9) && (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
    endfunction

    // Runs one conversion; returns timing and observations, leaves time at the Done cycle
    task automatic conv(input logic [9:0] b, output int busy_cnt, output int done_at,
                        output bit nib_ok, output bit overlap);
        busy_cnt = 0;
        done_at  = -1;
        nib_ok   = 1'b1;
        overlap  = 1'b0;
        @(negedge Clock);
        Start = 1'b1;
        Bin   = b;
        @(negedge Clock);
        Start = 1'b0;
        for (int n = 0; n < 20 && done_at < 0; n++) begin
            if (busy1 && done1) overlap = 1'b1;
            if (!nibs_ok(digits1) || !nibs_ok(digits0)) nib_ok = 1'b0;
            if (done1) begin
                done_at = n;
            end else begin
                if (busy1) busy_cnt++;
                Bin = 10'($urandom);
                @(negedge Clock);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b1;
        Bin   = 10'd555;
        repeat (3) @(negedge Clock);
        tests++;
        if ({digits1, busy1, done1, ovf1} !== 15'd0) begin
            fails++;
            $display("FAIL reset_outputs: got digits=%h busy=%b done=%b ovf=%b expected all zero",
                     digits1, busy1, done1, ovf1);
        end
        Start = 1'b0;
        Reset = 1'b0;
        @(negedge Clock);
        tests++;
        if ({digits0, busy0, done0, ovf0} !== 15'd0) begin
            fails++;
            $display("FAIL reset_release: got digits=%h busy=%b done=%b ovf=%b expected all zero",
                     digits0, busy0, done0, ovf0);
        end
    endtask

    task automatic test_zero();
        int bc, da;
        bit nk, ov;
        conv(10'd0, bc, da, nk, ov);
        tests++;
        if (bc !== 10) begin
            fails++; $display("FAIL zero_busy_cycles: got %0d expected 10", bc);
        end
        tests++;
        if (da !== 10) begin
            fails++; $display("FAIL zero_done_latency: got %0d expected 10", da);
        end
        tests++;
        if (digits1 !== 12'h000 || ovf1 !== 1'b0) begin
            fails++; $display("FAIL zero_result: got %h/%b expected 000/0", digits1, ovf1);
        end
        tests++;
        if (ov || busy1 !== 1'b0) begin
            fails++; $display("FAIL zero_busy_done_overlap: got overlap=%b busy=%b expected 0/0", ov, busy1);
        end
        @(negedge Clock);
        tests++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            fails++; $display("FAIL zero_done_pulse_width: got done=%b busy=%b expected 0/0", done1, busy1);
        end
    endtask

    task automatic test_values();
        int bc, da;
        bit nk, ov;
        logic [9:0] vals [3];
        vals[0] = 10'd999;
        vals[1] = 10'd507;
        vals[2] = 10'd1023;
        foreach (vals[i]) begin
            conv(vals[i], bc, da, nk, ov);
            tests++;
            if (digits1 !== model(int'(vals[i]), 1'b1) || ovf1 !== (vals[i] > 10'd999)) begin
                fails++;
                $display("FAIL value_sat_%0d: got %h/%b expected %h/%b", vals[i], digits1, ovf1,
                         model(int'(vals[i]), 1'b1), (vals[i] > 10'd999));
            end
            tests++;
            if (digits0 !== model(int'(vals[i]), 1'b0) || ovf0 !== (vals[i] > 10'd999)) begin
                fails++;
                $display("FAIL value_wrap_%0d: got %h/%b expected %h/%b", vals[i], digits0, ovf0,
                         model(int'(vals[i]), 1'b0), (vals[i] > 10'd999));
            end
            @(negedge Clock);
        end
    endtask

    task automatic test_back_to_back();
        int n_done;
        int at [4];
        logic [11:0] dg [4];
        n_done = 0;
        @(negedge Clock);
        Start = 1'b1;
        Bin   = 10'd42;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge Clock);
            if (done1) begin
                if (n_done < 4) begin
                    at[n_done] = cyc;
                    dg[n_done] = digits1;
                end
                n_done++;
            end
            if (cyc == 0) Bin = 10'd256;
            if (cyc == 12) begin
                Start = 1'b0;
                Bin   = 10'($urandom);
            end
        end
        tests++;
        if (n_done !== 2) begin
            fails++; $display("FAIL b2b_done_count: got %0d expected 2", n_done);
        end else begin
            tests++;
            if (at[0] !== 10 || dg[0] !== 12'h042) begin
                fails++; $display("FAIL b2b_first: got cycle %0d digits %h expected cycle 10 digits 042", at[0], dg[0]);
            end
            tests++;
            if (at[1] !== 22 || dg[1] !== 12'h256) begin
                fails++; $display("FAIL b2b_second: got cycle %0d digits %h expected cycle 22 digits 256", at[1], dg[1]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int bc, da;
        bit nk, ov, seen;
        conv(10'd42, bc, da, nk, ov);
        tests++;
        if (digits1 !== 12'h042) begin
            fails++; $display("FAIL abort_prior: got %h expected 042", digits1);
        end
        @(negedge Clock);
        @(negedge Clock);
        Start = 1'b1;
        Bin   = 10'd300;
        @(negedge Clock);
        Start = 1'b0;
        repeat (5) @(negedge Clock);
        tests++;
        if (busy1 !== 1'b1) begin
            fails++; $display("FAIL abort_busy_mid: got %b expected 1", busy1);
        end
        #1 Reset = 1'b1;
        #1;
        tests++;
        if (digits1 !== 12'h000 || busy1 !== 1'b0 || done1 !== 1'b0 || ovf1 !== 1'b0) begin
            fails++;
            $display("FAIL abort_immediate: got digits=%h busy=%b done=%b ovf=%b expected 000/0/0/0",
                     digits1, busy1, done1, ovf1);
        end
        @(negedge Clock);
        Reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge Clock);
            if (done1 || done0 || busy1) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++; $display("FAIL abort_no_done: got activity after reset expected none");
        end
        conv(10'd300, bc, da, nk, ov);
        tests++;
        if (digits1 !== 12'h300 || da !== 10) begin
            fails++; $display("FAIL abort_restart: got %h at %0d expected 300 at 10", digits1, da);
        end
        @(negedge Clock);
    endtask

    task automatic test_sweep();
        int bc, da;
        bit nk, ov;
        for (int b = 0; b < 1024; b++) begin
            repeat ($urandom_range(0, 2)) @(negedge Clock);
            conv(10'(b), bc, da, nk, ov);
            tests++;
            if (da !== 10 || bc !== 10 || ov) begin
                fails++;
                $display("FAIL sweep_timing_%0d: got done_at=%0d busy=%0d overlap=%b expected 10/10/0", b, da, bc, ov);
            end
            tests++;
            if (digits1 !== model(b, 1'b1) || ovf1 !== (b > 999)) begin
                fails++;
                $display("FAIL sweep_sat_%0d: got %h/%b expected %h/%b", b, digits1, ovf1, model(b, 1'b1), (b > 999));
            end
            tests++;
            if (digits0 !== model(b, 1'b0) || ovf0 !== (b > 999)) begin
                fails++;
                $display("FAIL sweep_wrap_%0d: got %h/%b expected %h/%b", b, digits0, ovf0, model(b, 1'b0), (b > 999));
            end
            tests++;
            if (!nk || !nibs_ok(digits1) || !nibs_ok(digits0)) begin
                fails++; $display("FAIL sweep_nibble_%0d: got %h/%h expected BCD only", b, digits1, digits0);
            end
            @(negedge Clock);
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        Bin   = 10'd0;
        test_reset();
        test_zero();
        test_values();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter SATURATE, default 1: 1 = inputs above 999 give result 999; 0 = result is the input modulo 1000.
REQ-002 SHALL have port Clock  input  1  single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  conversion request, sampled on the rising edge of Clock.
REQ-005 SHALL have port Bin  input  10  unsigned binary operand, 0..1023, sampled in the same cycle as an accepted Start.
REQ-006 SHALL have port Digits  output  12  BCD result: [11:8] hundreds, [7:4] tens, [3:0] units; drives the 3-digit seven-segment display stage.
REQ-007 SHALL have port Busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port Done  output  1  one-cycle pulse marking a new valid Digits value.
REQ-009 SHALL have port Ovf  output  1  high when the last converted Bin exceeded 999.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-011 SHALL accept Start only in IDLE; at that edge k it SHALL capture Bin, clear the 12-bit BCD scratch and the 4-bit iteration counter, and enter SHIFT.
REQ-012 SHALL ignore Start while in SHIFT or DONE, with no effect on state, the captured operand, or the outputs.
REQ-013 Each SHIFT cycle SHALL perform one shift-add-3 iteration: add 3 to every scratch digit >= 5, then left-shift {scratch, operand} by one bit.
REQ-014 After exactly 10 iterations (edges k+1..k+10), the FSM SHALL enter DONE at edge k+10 and load Digits and Ovf in the same edge.
REQ-015 The FSM SHALL assert Done only in DONE, for exactly one cycle, and then return to IDLE on the next edge (k+11).
REQ-016 Busy SHALL be high exactly while in SHIFT, i.e. the 10 cycles following edge k; Busy and Done SHALL never be high together.
REQ-017 Digits and Ovf SHALL hold their value from one conversion until the next DONE entry; they SHALL be unaffected in IDLE and SHIFT.
REQ-018 Ovf SHALL equal (captured Bin > 999).
REQ-019 With SATURATE=1 and Ovf=1, Digits SHALL be 12'h999.
REQ-020 With SATURATE=0, Digits SHALL be the low three BCD digits of the full conversion, dropping the thousands digit (1000..1023 -> 000..023).
REQ-021 The earliest next Start acceptance SHALL be the edge following DONE, giving a back-to-back throughput of one conversion per 12 cycles.
REQ-022 Digits SHALL never hold a non-BCD nibble (A..F) at any time outside reset.

Reset
REQ-023 Reset high SHALL immediately force state IDLE, Digits=12'h000, Busy=0, Done=0, Ovf=0, and clear the counter and scratch, regardless of Clock.
REQ-024 Reset asserted during SHIFT or DONE SHALL abort the conversion without a Done pulse; the first Start after Reset deasserts SHALL be accepted normally.

Structure
REQ-025 A shared package SHALL hold the state encoding type, BIN_W=10, BCD_W=12, N_ITER=10, and MAX_VAL=999.
REQ-026 The per-digit "add 3 if >= 5" correction SHALL be a combinational sub-module, bcd_add3, instantiated once per digit.
REQ-027 Digits SHALL connect directly to the existing 3-digit seven-segment display group's 12-bit BCD input without remapping.

Verification
REQ-028 SHALL cover: Bin=0, Start pulsed at edge k -> Busy high for 10 cycles, Done high in the cycle after edge k+10, Digits=12'h000, Ovf=0.
REQ-029 SHALL cover: Bin=999 and Bin=507 -> Digits=12'h999 and 12'h507, Ovf=0.
REQ-030 SHALL cover: Bin=1023 with SATURATE=1 -> Digits=12'h999, Ovf=1; with SATURATE=0 -> Digits=12'h023, Ovf=1.
REQ-031 SHALL cover: Start held high continuously with Bin=42 then 256 -> one conversion per 12 cycles, Digits=12'h042 then 12'h256; Bin changes during SHIFT have no effect.
REQ-032 SHALL cover: Reset pulsed at iteration 5 of converting 300, with the prior Digits=12'h042 -> Digits=12'h000 and Busy=0 immediately, no Done pulse; a following Start with 300 -> 12'h300.
REQ-033 SHALL cover: exhaustive sweep of Bin 0..1023 checked against a reference model; no nibble above 9 on Digits at any time.
